load_store_unit: RTL and testbench

Pipeline-side initiator for the 16-word data memory: takes one load/store request at a time from the execute stage and drives the memory's `addr`/`write_data`/`ldr_str_en`/`load_en`/`store_en` port. It accepts byte addresses and byte/halfword/word sizes. Sub-word stores are done as read-modify-write, and loaded data is returned zero- or sign-extended through a valid/ready response. Misaligned or reserved-size requests return an error and never touch memory.

---
 rtl/load_store_unit_if.sv | 37 +++
 rtl/load_store_unit.sv | 137 +++++++++++++
 tb/tb_load_store_unit.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Request/response/memory-port bundle between the execute stage, the
// load/store unit and the 16-word data memory.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [5:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [3:0]  mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_ldr_str_en;
  logic        mem_load_en;
  logic        mem_store_en;
  logic [31:0] mem_read_data;

  // Environment side: issues requests, consumes responses, models memory.
  modport master (
    output req_valid, req_store, req_size, req_signed, req_addr, req_wdata,
    output rsp_ready, mem_read_data,
    input  req_ready, rsp_valid, rsp_data, rsp_err,
    input  mem_addr, mem_write_data, mem_ldr_str_en, mem_load_en, mem_store_en
  );

  // Load/store unit side.
  modport slave (
    input  req_valid, req_store, req_size, req_signed, req_addr, req_wdata,
    input  rsp_ready, mem_read_data,
    output req_ready, rsp_valid, rsp_data, rsp_err,
    output mem_addr, mem_write_data, mem_ldr_str_en, mem_load_en, mem_store_en
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, byte/half/word accesses to a
// 16 x 32-bit memory, read-modify-write for sub-word stores, extended loads.
module load_store_unit (
  input  logic              clk,
  input  logic              rst,
  load_store_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      state_q, state_d;
  logic        store_q, store_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [5:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;

  logic        req_bad;
  logic [4:0]  lane_shift;
  logic [31:0] byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;
  logic [31:0] lane_mask;
  logic [31:0] lane_data;
  logic [31:0] merged;

  // Reserved size or misaligned half/word access is rejected at accept.
  always_comb begin
    req_bad = 1'b0;
    case (bus.req_size)
      2'b01:   req_bad = bus.req_addr[0];
      2'b10:   req_bad = (bus.req_addr[1:0] != 2'b00);
      2'b11:   req_bad = 1'b1;
      default: req_bad = 1'b0;
    endcase
  end

  // State register and request/data latches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      store_q  <= 1'b0;
      size_q   <= '0;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      store_q  <= store_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      data_q   <= data_d;
      err_q    <= err_d;
    end
  end

  // Next-state: sequencing of accept, read, write and response.
  always_comb begin
    state_d  = state_q;
    store_d  = store_q;
    size_d   = size_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    data_d   = data_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          store_d  = bus.req_store;
          size_d   = bus.req_size;
          signed_d = bus.req_signed;
          addr_d   = bus.req_addr;
          wdata_d  = bus.req_wdata;
          err_d    = req_bad;
          if (req_bad)
            state_d = RESP;
          else if (bus.req_store && bus.req_size == 2'b10)
            state_d = WR;
          else
            state_d = RD;
        end
      end
      RD: begin
        data_d  = bus.mem_read_data;
        state_d = store_q ? WR : RESP;
      end
      WR:      state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Lane extract for loads and lane merge for sub-word stores (little-endian).
  always_comb begin
    lane_shift = {addr_q[1:0], 3'b000};
    byte_sel   = data_q >> lane_shift;
    half_sel   = addr_q[1] ? data_q[31:16] : data_q[15:0];
    case (size_q)
      2'b00:   load_ext = {{24{signed_q & byte_sel[7]}}, byte_sel[7:0]};
      2'b01:   load_ext = {{16{signed_q & half_sel[15]}}, half_sel};
      default: load_ext = data_q;
    endcase
    lane_mask = '0;
    lane_data = '0;
    merged    = wdata_q;
    if (size_q == 2'b00) begin
      lane_mask = 32'h0000_00ff << lane_shift;
      lane_data = {24'h0, wdata_q[7:0]} << lane_shift;
      merged    = (data_q & ~lane_mask) | lane_data;
    end else if (size_q == 2'b01) begin
      lane_mask = 32'h0000_ffff << lane_shift;
      lane_data = {16'h0, wdata_q[15:0]} << lane_shift;
      merged    = (data_q & ~lane_mask) | lane_data;
    end
  end

  // Outputs decoded straight from the state register.
  always_comb begin
    bus.req_ready      = (state_q == IDLE);
    bus.rsp_valid      = (state_q == RESP);
    bus.rsp_err        = (state_q == RESP) && err_q;
    bus.rsp_data       = ((state_q == RESP) && !err_q && !store_q) ? load_ext : '0;
    bus.mem_addr       = (state_q == RD || state_q == WR) ? addr_q[5:2] : '0;
    bus.mem_write_data = (state_q == WR) ? merged : '0;
    bus.mem_ldr_str_en = (state_q == RD || state_q == WR);
    bus.mem_load_en    = (state_q == RD);
    bus.mem_store_en   = (state_q == WR);
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural 16-word memory.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if lsu_if ();

  load_store_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (lsu_if)
  );

  logic [31:0] mem [16];
  logic        pre_we = 1'b0;
  logic [3:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;

  always_comb lsu_if.mem_read_data = mem[lsu_if.mem_addr];

  always @(posedge clk) begin
    if (lsu_if.mem_store_en)
      mem[lsu_if.mem_addr] <= lsu_if.mem_write_data;
    else if (pre_we)
      mem[pre_addr] <= pre_data;
  end

  int n_checks = 0;
  int n_fail   = 0;

  int          lat, nrd, nwr;
  logic [3:0]  ard, awr;
  logic [31:0] wd, rdata;
  logic        rerr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [3:0] a, input logic [31:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    tick();
    pre_we   = 1'b0;
  endtask

  // Issue one request, then follow it until rsp_valid (bounded), recording
  // latency, memory enables, addresses and the write word.
  task automatic issue(input logic st, input logic [1:0] sz, input logic sg,
                       input logic [5:0] a, input logic [31:0] w);
    lsu_if.req_store  = st;
    lsu_if.req_size   = sz;
    lsu_if.req_signed = sg;
    lsu_if.req_addr   = a;
    lsu_if.req_wdata  = w;
    lsu_if.req_valid  = 1'b1;
    tick();
    lsu_if.req_valid  = 1'b0;
    lsu_if.req_wdata  = 32'h5a5a_5a5a;
    lsu_if.req_addr   = 6'h3f;
    lsu_if.req_size   = 2'b10;
    lsu_if.req_signed = ~sg;
    lat = 1; nrd = 0; nwr = 0; ard = '0; awr = '0; wd = '0;
    rdata = '0; rerr = 1'b0;
    while (lat <= 10) begin
      if (lsu_if.mem_load_en)  begin nrd++; ard = lsu_if.mem_addr; end
      if (lsu_if.mem_store_en) begin nwr++; awr = lsu_if.mem_addr; wd = lsu_if.mem_write_data; end
      if (lsu_if.rsp_valid) begin
        rdata = lsu_if.rsp_data;
        rerr  = lsu_if.rsp_err;
        break;
      end
      tick();
      lat++;
    end
  endtask

  task automatic complete();
    tick();
    check("post_rsp_valid", {31'b0, lsu_if.rsp_valid}, 32'd0);
    check("post_req_ready", {31'b0, lsu_if.req_ready}, 32'd1);
  endtask

  initial begin
    lsu_if.req_valid  = 1'b0;
    lsu_if.req_store  = 1'b0;
    lsu_if.req_size   = '0;
    lsu_if.req_signed = 1'b0;
    lsu_if.req_addr   = '0;
    lsu_if.req_wdata  = '0;
    lsu_if.rsp_ready  = 1'b1;
    #12;
    check("rst_req_ready", {31'b0, lsu_if.req_ready}, 32'd1);
    check("rst_rsp_valid", {31'b0, lsu_if.rsp_valid}, 32'd0);
    check("rst_rsp_err",   {31'b0, lsu_if.rsp_err}, 32'd0);
    check("rst_rsp_data",  lsu_if.rsp_data, 32'd0);
    check("rst_mem_en",    {29'b0, lsu_if.mem_ldr_str_en, lsu_if.mem_load_en, lsu_if.mem_store_en}, 32'd0);
    check("rst_mem_addr",  {28'b0, lsu_if.mem_addr}, 32'd0);
    check("rst_mem_wdata", lsu_if.mem_write_data, 32'd0);
    rst = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) preload(4'(i), 32'h0);

    // Word round-trip.
    issue(1'b1, 2'b10, 1'b0, 6'h08, 32'hdead_beef);
    check("sw_lat", lat, 2);
    check("sw_nrd", nrd, 0);
    check("sw_nwr", nwr, 1);
    check("sw_addr", {28'b0, awr}, 32'd2);
    check("sw_wdata", wd, 32'hdead_beef);
    check("sw_rsp_data", rdata, 32'd0);
    check("sw_rsp_err", {31'b0, rerr}, 32'd0);
    complete();
    check("sw_mem", mem[2], 32'hdead_beef);
    issue(1'b0, 2'b10, 1'b1, 6'h08, 32'h0);
    check("lw_lat", lat, 2);
    check("lw_nrd", nrd, 1);
    check("lw_nwr", nwr, 0);
    check("lw_addr", {28'b0, ard}, 32'd2);
    check("lw_data", rdata, 32'hdead_beef);
    check("lw_err", {31'b0, rerr}, 32'd0);
    complete();

    // Byte store read-modify-write.
    preload(4'd3, 32'h1122_3344);
    issue(1'b1, 2'b00, 1'b0, 6'h0d, 32'hffff_ffaa);
    check("sb_lat", lat, 3);
    check("sb_nrd", nrd, 1);
    check("sb_nwr", nwr, 1);
    check("sb_ard", {28'b0, ard}, 32'd3);
    check("sb_awr", {28'b0, awr}, 32'd3);
    check("sb_wdata", wd, 32'h1122_aa44);
    complete();
    check("sb_mem", mem[3], 32'h1122_aa44);

    // Half store to upper lane.
    issue(1'b1, 2'b01, 1'b0, 6'h0e, 32'h0000_beef);
    check("sh_lat", lat, 3);
    check("sh_wdata", wd, 32'hbeef_aa44);
    complete();

    // Sign / zero extension.
    preload(4'd4, 32'h8000_f0ff);
    issue(1'b0, 2'b01, 1'b1, 6'h12, 32'h0);
    check("lh_s_hi", rdata, 32'hffff_8000);
    complete();
    issue(1'b0, 2'b01, 1'b0, 6'h10, 32'h0);
    check("lh_u_lo", rdata, 32'h0000_f0ff);
    complete();
    issue(1'b0, 2'b00, 1'b0, 6'h10, 32'h0);
    check("lb_u_0", rdata, 32'h0000_00ff);
    check("lb_u_0_lat", lat, 2);
    complete();
    issue(1'b0, 2'b00, 1'b1, 6'h11, 32'h0);
    check("lb_s_1", rdata, 32'hffff_fff0);
    complete();
    issue(1'b0, 2'b00, 1'b0, 6'h13, 32'h0);
    check("lb_u_3", rdata, 32'h0000_0080);
    complete();

    // Error cases.
    issue(1'b0, 2'b10, 1'b0, 6'h05, 32'h0);
    check("err_lw_lat", lat, 1);
    check("err_lw_err", {31'b0, rerr}, 32'd1);
    check("err_lw_data", rdata, 32'd0);
    check("err_lw_mem", nrd + nwr, 0);
    complete();
    issue(1'b1, 2'b01, 1'b0, 6'h03, 32'h1234_5678);
    check("err_sh_lat", lat, 1);
    check("err_sh_err", {31'b0, rerr}, 32'd1);
    check("err_sh_mem", nrd + nwr, 0);
    complete();
    check("err_sh_memword", mem[0], 32'd0);
    issue(1'b0, 2'b11, 1'b0, 6'h00, 32'h0);
    check("err_sz_lat", lat, 1);
    check("err_sz_err", {31'b0, rerr}, 32'd1);
    check("err_sz_data", rdata, 32'd0);
    check("err_sz_mem", nrd + nwr, 0);
    complete();

    // Backpressure on the response.
    lsu_if.rsp_ready = 1'b0;
    issue(1'b0, 2'b10, 1'b0, 6'h08, 32'h0);
    check("bp_lat", lat, 2);
    lsu_if.req_store = 1'b1;
    lsu_if.req_size  = 2'b10;
    lsu_if.req_addr  = 6'h00;
    lsu_if.req_wdata = 32'h0bad_0bad;
    lsu_if.req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_rsp_valid", {31'b0, lsu_if.rsp_valid}, 32'd1);
      check("bp_rsp_data", lsu_if.rsp_data, 32'hdead_beef);
      check("bp_req_ready", {31'b0, lsu_if.req_ready}, 32'd0);
      check("bp_mem_en", {29'b0, lsu_if.mem_ldr_str_en, lsu_if.mem_load_en, lsu_if.mem_store_en}, 32'd0);
    end
    lsu_if.req_valid = 1'b0;
    lsu_if.rsp_ready = 1'b1;
    complete();
    tick();
    check("bp_no_accept", {31'b0, lsu_if.req_ready}, 32'd1);
    check("bp_mem0", mem[0], 32'd0);

    // Reset during the read of a byte store.
    preload(4'd5, 32'hcafe_babe);
    lsu_if.req_store  = 1'b1;
    lsu_if.req_size   = 2'b00;
    lsu_if.req_signed = 1'b0;
    lsu_if.req_addr   = 6'h14;
    lsu_if.req_wdata  = 32'h0000_0055;
    lsu_if.req_valid  = 1'b1;
    tick();
    lsu_if.req_valid  = 1'b0;
    check("rr_in_rd", {31'b0, lsu_if.mem_load_en}, 32'd1);
    rst = 1'b0;
    #1;
    check("rr_mem_en", {29'b0, lsu_if.mem_ldr_str_en, lsu_if.mem_load_en, lsu_if.mem_store_en}, 32'd0);
    check("rr_mem_addr", {28'b0, lsu_if.mem_addr}, 32'd0);
    check("rr_rsp_valid", {31'b0, lsu_if.rsp_valid}, 32'd0);
    check("rr_req_ready", {31'b0, lsu_if.req_ready}, 32'd1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("rr_after_ready", {31'b0, lsu_if.req_ready}, 32'd1);
    check("rr_after_store_en", {31'b0, lsu_if.mem_store_en}, 32'd0);
    check("rr_after_rsp_valid", {31'b0, lsu_if.rsp_valid}, 32'd0);
    check("rr_mem5", mem[5], 32'hcafe_babe);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
